// File: rtl/kfpga_config_loader.sv
// Bitstream loader for the kFPGA configuration chain: serialises stream words LSB-first,
// optionally recirculates the chain to check its ones-count, then releases the core enable.
module kfpga_config_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 1024,
  parameter int VERIFY       = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  cfg_data,
  output logic                  cfg_enable,
  output logic                  cfg_nreset,
  input  logic                  cfg_return,
  output logic                  core_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int CW        = $clog2(CHAIN_LENGTH + 1);
  localparam int NUM_WORDS = (CHAIN_LENGTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int LAST_BITS = CHAIN_LENGTH - (NUM_WORDS - 1) * WORD_WIDTH;
  localparam int HW        = $clog2(WORD_WIDTH + 1);
  localparam int WCW       = $clog2(NUM_WORDS + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_LOAD, ST_VERIFY, ST_DONE, ST_ERROR
  } state_t;

  state_t                state_reg;
  logic [WORD_WIDTH-1:0] shift_buf_reg;
  logic [HW-1:0]         held_reg;
  logic [WCW-1:0]        words_reg;
  logic [CW-1:0]         bits_sent_reg;
  logic [CW-1:0]         ones_loaded_reg;
  logic [CW-1:0]         ones_seen_reg;
  logic [CW-1:0]         verify_cnt_reg;
  logic                  cfg_nreset_reg;
  logic                  core_enable_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  error_reg;

  logic                  load_shift;
  logic                  words_left;
  logic                  accept;
  logic [HW-1:0]         load_bits;
  logic [CW-1:0]         seen_total;

  assign load_shift = (state_reg == ST_LOAD) && (held_reg != '0);
  assign words_left = (words_reg != WCW'(NUM_WORDS));
  // Accepting while the last held bit shifts out keeps back-to-back words gapless.
  assign s_ready    = (state_reg == ST_LOAD) && words_left &&
                      ((held_reg == '0) || (held_reg == HW'(1)));
  assign accept     = s_ready && s_valid;
  // The final word only carries the bits that still fit in the chain.
  assign load_bits  = (words_reg == WCW'(NUM_WORDS - 1)) ? HW'(LAST_BITS) : HW'(WORD_WIDTH);
  assign seen_total = ones_seen_reg + CW'(cfg_return);

  // During verify the chain output feeds straight back into its input.
  assign cfg_enable  = load_shift || (state_reg == ST_VERIFY);
  assign cfg_data    = (state_reg == ST_VERIFY) ? cfg_return : (load_shift & shift_buf_reg[0]);
  assign cfg_nreset  = cfg_nreset_reg;
  assign core_enable = core_enable_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign error       = error_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      shift_buf_reg   <= '0;
      held_reg        <= '0;
      words_reg       <= '0;
      bits_sent_reg   <= '0;
      ones_loaded_reg <= '0;
      ones_seen_reg   <= '0;
      verify_cnt_reg  <= '0;
      cfg_nreset_reg  <= 1'b1;
      core_enable_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      error_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_reg       <= ST_CLEAR;
            busy_reg        <= 1'b1;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
            core_enable_reg <= 1'b0;
            cfg_nreset_reg  <= 1'b0;
          end
        end
        ST_CLEAR: begin
          state_reg       <= ST_LOAD;
          cfg_nreset_reg  <= 1'b1;
          held_reg        <= '0;
          words_reg       <= '0;
          bits_sent_reg   <= '0;
          ones_loaded_reg <= '0;
          ones_seen_reg   <= '0;
          verify_cnt_reg  <= '0;
        end
        ST_LOAD: begin
          if (load_shift) begin
            bits_sent_reg   <= bits_sent_reg + CW'(1);
            ones_loaded_reg <= ones_loaded_reg + CW'(shift_buf_reg[0]);
          end
          if (accept) begin
            shift_buf_reg <= s_data;
            held_reg      <= load_bits;
            words_reg     <= words_reg + WCW'(1);
          end else if (load_shift) begin
            shift_buf_reg <= shift_buf_reg >> 1;
            held_reg      <= held_reg - HW'(1);
          end
          if (load_shift && (bits_sent_reg == CW'(CHAIN_LENGTH - 1))) begin
            verify_cnt_reg <= '0;
            if (VERIFY != 0) begin
              state_reg <= ST_VERIFY;
            end else begin
              state_reg       <= ST_DONE;
              busy_reg        <= 1'b0;
              done_reg        <= 1'b1;
              core_enable_reg <= 1'b1;
            end
          end
        end
        ST_VERIFY: begin
          ones_seen_reg  <= seen_total;
          verify_cnt_reg <= verify_cnt_reg + CW'(1);
          if (verify_cnt_reg == CW'(CHAIN_LENGTH - 1)) begin
            busy_reg <= 1'b0;
            if (seen_total == ones_loaded_reg) begin
              state_reg       <= ST_DONE;
              done_reg        <= 1'b1;
              core_enable_reg <= 1'b1;
            end else begin
              state_reg <= ST_ERROR;
              error_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
